// File: rtl/multicycle_main_control_if.sv
// Control-to-datapath bundle for the multicycle CPU main controller.
// The controller takes the master side. The datapath, or a bench standing in for it, takes the slave side.
interface multicycle_main_control_if;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_en;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [2:0] alu_op;
    logic       illegal;
    logic [3:0] state;

    modport master (
        input  opcode, zero, mem_ready,
        output pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
               reg_write, alu_src_a, alu_src_b, pc_src, alu_op, illegal, state
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
               reg_write, alu_src_a, alu_src_b, pc_src, alu_op, illegal, state
    );
endinterface

// File: rtl/multicycle_main_control.sv
// Main control FSM of the multicycle CPU. It steps fetch/decode/execute/memory/writeback
// and produces the datapath enables and mux selects.
module multicycle_main_control #(
    parameter logic [2:0] ALUOP_ADD = 3'b010,
    parameter logic [2:0] ALUOP_SUB = 3'b110
) (
    input  logic                      clk,
    input  logic                      reset,
    multicycle_main_control_if.master bus
);
    // The ALU control decoder hard-codes this value as "decode funct".
    localparam logic [2:0] ALUOP_RTYPE = 3'b111;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_e;

    state_e state_q, state_d;
    // The opcode is only valid in DECODE, so MEMADR needs the lw/sw choice remembered.
    logic   is_store_q, is_store_d;

    logic       pc_en, iord, mem_read, mem_write, ir_write;
    logic       reg_dst, mem_to_reg, reg_write, alu_src_a, illegal;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_op;

    function automatic logic known_opcode(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ)   || (op == OP_ADDI) || (op == OP_J);
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every flop samples its pre-edge value.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_FETCH;
            is_store_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            is_store_q <= is_store_d;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        is_store_d = is_store_q;
        case (state_q)
            S_FETCH: begin
                if (bus.mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                is_store_d = (bus.opcode == OP_SW);
                case (bus.opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: state_d = is_store_q ? S_MEMWR : S_MEMRD;
            S_MEMRD: begin
                if (bus.mem_ready) state_d = S_MEMWB;
            end
            S_MEMWR: begin
                if (bus.mem_ready) state_d = S_FETCH;
            end
            S_EXEC:   state_d = S_ALUWB;
            S_ADDIEX: state_d = S_ADDIWB;
            S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    // Outputs are gated by reset so an instruction that reset interrupts cannot write anything.
    always_comb begin
        pc_en      = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        pc_src     = 2'b00;
        alu_op     = ALUOP_ADD;
        illegal    = 1'b0;
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write  = bus.mem_ready;
                    pc_en     = bus.mem_ready;
                end
                S_DECODE: begin
                    alu_src_b = 2'b11;
                    illegal   = !known_opcode(bus.opcode);
                end
                S_MEMADR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                S_MEMRD: begin
                    iord     = 1'b1;
                    mem_read = 1'b1;
                end
                S_MEMWB: begin
                    mem_to_reg = 1'b1;
                    reg_write  = 1'b1;
                end
                S_MEMWR: begin
                    iord      = 1'b1;
                    mem_write = 1'b1;
                end
                S_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_op    = ALUOP_RTYPE;
                end
                S_ALUWB: begin
                    reg_dst   = 1'b1;
                    reg_write = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a = 1'b1;
                    alu_op    = ALUOP_SUB;
                    pc_src    = 2'b01;
                    pc_en     = bus.zero;
                end
                S_ADDIEX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                S_ADDIWB: reg_write = 1'b1;
                S_JUMP: begin
                    pc_src = 2'b10;
                    pc_en  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.pc_en      = pc_en;
    assign bus.iord       = iord;
    assign bus.mem_read   = mem_read;
    assign bus.mem_write  = mem_write;
    assign bus.ir_write   = ir_write;
    assign bus.reg_dst    = reg_dst;
    assign bus.mem_to_reg = mem_to_reg;
    assign bus.reg_write  = reg_write;
    assign bus.alu_src_a  = alu_src_a;
    assign bus.alu_src_b  = alu_src_b;
    assign bus.pc_src     = pc_src;
    assign bus.alu_op     = alu_op;
    assign bus.illegal    = illegal;
    assign bus.state      = state_q;
endmodule

// File: tb/tb_multicycle_main_control.sv
// Self-checking bench for multicycle_main_control. Instruction-level sequencing builds a queue of
// expected per-cycle outputs, and one compare process checks the DUT against that queue at every falling edge.
module tb_multicycle_main_control;
    localparam int ST_FETCH = 0, ST_DECODE = 1, ST_MEMADR = 2, ST_MEMRD = 3, ST_MEMWB = 4;
    localparam int ST_MEMWR = 5, ST_EXEC = 6, ST_ALUWB = 7, ST_BRANCH = 8, ST_ADDIEX = 9;
    localparam int ST_ADDIWB = 10, ST_JUMP = 11;

    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;
    localparam logic [5:0] OP_BAD = 6'b111111;

    typedef struct packed {
        logic [3:0] state;
        logic       pc_en, iord, mem_read, mem_write, ir_write;
        logic       reg_dst, mem_to_reg, reg_write, alu_src_a;
        logic [1:0] alu_src_b, pc_src;
        logic [2:0] alu_op;
        logic       illegal;
    } obs_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   fails = 0;

    obs_t  exp_q[$];
    string tag_q[$];
    obs_t  hist[$];
    obs_t  act_obs, exp_obs;
    string exp_tag;

    multicycle_main_control_if bus();

    multicycle_main_control dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected outputs for one cycle in a given controller step, from the state table.
    function automatic obs_t spec_out(input int st, input bit rst, input bit rdy, input bit z,
                                      input bit bad_op);
        obs_t o;
        o        = '0;
        o.state  = st[3:0];
        o.alu_op = 3'b010;
        if (rst) return o;
        case (st)
            ST_FETCH:  begin o.mem_read = 1; o.alu_src_b = 2'b01; o.ir_write = rdy; o.pc_en = rdy; end
            ST_DECODE: begin o.alu_src_b = 2'b11; o.illegal = bad_op; end
            ST_MEMADR: begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
            ST_MEMRD:  begin o.iord = 1; o.mem_read = 1; end
            ST_MEMWB:  begin o.mem_to_reg = 1; o.reg_write = 1; end
            ST_MEMWR:  begin o.iord = 1; o.mem_write = 1; end
            ST_EXEC:   begin o.alu_src_a = 1; o.alu_op = 3'b111; end
            ST_ALUWB:  begin o.reg_dst = 1; o.reg_write = 1; end
            ST_BRANCH: begin o.alu_src_a = 1; o.alu_op = 3'b110; o.pc_src = 2'b01; o.pc_en = z; end
            ST_ADDIEX: begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
            ST_ADDIWB: o.reg_write = 1;
            ST_JUMP:   begin o.pc_src = 2'b10; o.pc_en = 1; end
            default: ;
        endcase
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.state      = bus.state;
        o.pc_en      = bus.pc_en;
        o.iord       = bus.iord;
        o.mem_read   = bus.mem_read;
        o.mem_write  = bus.mem_write;
        o.ir_write   = bus.ir_write;
        o.reg_dst    = bus.reg_dst;
        o.mem_to_reg = bus.mem_to_reg;
        o.reg_write  = bus.reg_write;
        o.alu_src_a  = bus.alu_src_a;
        o.alu_src_b  = bus.alu_src_b;
        o.pc_src     = bus.pc_src;
        o.alu_op     = bus.alu_op;
        o.illegal    = bus.illegal;
        return o;
    endfunction

    function automatic obs_t hst(input int i);
        if (i < hist.size()) return hist[i];
        return '1;
    endfunction

    function automatic int count_where(input int kind);
        int n = 0;
        foreach (hist[i]) begin
            case (kind)
                0: n += int'(hist[i].state == 4'd3 && hist[i].iord);
                1: n += int'(hist[i].reg_write);
                2: n += int'(hist[i].reg_write && hist[i].mem_to_reg);
                3: n += int'(hist[i].mem_write);
                4: n += int'(hist[i].reg_write || hist[i].mem_write);
                default: n += int'(hist[i].state == 4'd3);
            endcase
        end
        return n;
    endfunction

    function automatic bit noise();
        return 1'($urandom_range(0, 1));
    endfunction

    // Compare process: one expectation per cycle, checked at the falling edge.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_obs = exp_q.pop_front();
            exp_tag = tag_q.pop_front();
            act_obs = sample();
            hist.push_back(act_obs);
            check(exp_tag, 32'(act_obs), 32'(exp_obs));
        end
    end

    task automatic cycle(input int st, input bit rst, input bit rdy, input bit z,
                         input logic [5:0] op, input string tag);
        @(posedge clk);
        #1;
        reset         = rst;
        bus.mem_ready = rdy;
        bus.zero      = z;
        bus.opcode    = op;
        exp_q.push_back(spec_out(st, rst, rdy, z, st == ST_DECODE &&
            !(op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J})));
        tag_q.push_back(tag);
    endtask

    // The cycle sequence of one instruction, from its opcode and the memory stall counts.
    // Inputs that the current step ignores carry noise, and the opcode is wrong outside DECODE.
    task automatic run_instr(input logic [5:0] op, input int fetch_stall, input int mem_stall,
                             input bit z);
        for (int i = 0; i < fetch_stall; i++) cycle(ST_FETCH, 0, 0, noise(), OP_BAD, "fetch_wait");
        cycle(ST_FETCH, 0, 1, noise(), OP_BAD, "fetch");
        cycle(ST_DECODE, 0, noise(), noise(), op, "decode");
        case (op)
            OP_R: begin
                cycle(ST_EXEC, 0, noise(), noise(), OP_BAD, "exec");
                cycle(ST_ALUWB, 0, noise(), noise(), OP_BAD, "aluwb");
            end
            OP_LW: begin
                cycle(ST_MEMADR, 0, noise(), noise(), OP_BAD, "memadr_lw");
                for (int i = 0; i < mem_stall; i++) cycle(ST_MEMRD, 0, 0, noise(), OP_BAD, "memrd_wait");
                cycle(ST_MEMRD, 0, 1, noise(), OP_BAD, "memrd");
                cycle(ST_MEMWB, 0, noise(), noise(), OP_BAD, "memwb");
            end
            OP_SW: begin
                cycle(ST_MEMADR, 0, noise(), noise(), OP_BAD, "memadr_sw");
                for (int i = 0; i < mem_stall; i++) cycle(ST_MEMWR, 0, 0, noise(), OP_BAD, "memwr_wait");
                cycle(ST_MEMWR, 0, 1, noise(), OP_BAD, "memwr");
            end
            OP_BEQ:  cycle(ST_BRANCH, 0, noise(), z, OP_BAD, "branch");
            OP_ADDI: begin
                cycle(ST_ADDIEX, 0, noise(), noise(), OP_BAD, "addiex");
                cycle(ST_ADDIWB, 0, noise(), noise(), OP_BAD, "addiwb");
            end
            OP_J:    cycle(ST_JUMP, 0, noise(), noise(), OP_BAD, "jump");
            default: ;
        endcase
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 time units");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.opcode    = OP_BAD;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b0;
        reset         = 1'b1;
        repeat (2) @(posedge clk);

        // Reset state
        hist.delete();
        cycle(ST_FETCH, 1, 1, 1, OP_BAD, "reset_hold");
        settle();
        check("reset_state_and_enables", {hst(0).state, hst(0).mem_read, hst(0).reg_write, hst(0).pc_en},
              {4'd0, 3'b000});

        // T2: R-type, no stalls
        hist.delete();
        run_instr(OP_R, 0, 0, 0);
        settle();
        check("t2_len", hist.size(), 4);
        check("t2_states", {hst(0).state, hst(1).state, hst(2).state, hst(3).state}, 16'h0167);
        check("t2_exec_aluop", hst(2).alu_op, 3'b111);
        check("t2_aluwb_wr_dst", {hst(3).reg_write, hst(3).reg_dst}, 2'b11);

        // T1: reset held for 2 cycles starting in EXEC
        hist.delete();
        cycle(ST_FETCH, 0, 1, noise(), OP_BAD, "t1_fetch");
        cycle(ST_DECODE, 0, noise(), noise(), OP_R, "t1_decode");
        cycle(ST_EXEC, 1, noise(), noise(), OP_BAD, "t1_reset_exec");
        cycle(ST_FETCH, 1, noise(), noise(), OP_BAD, "t1_reset_fetch");
        cycle(ST_FETCH, 0, 0, noise(), OP_BAD, "t1_release_fetch");
        settle();
        check("t1_abort_no_write", {hst(2).state, hst(2).reg_write, hst(2).alu_op}, {4'd6, 1'b0, 3'b010});
        check("t1_state_after_reset", hst(3).state, 4'd0);
        check("t1_release_mem_read", {hst(4).state, hst(4).mem_read}, {4'd0, 1'b1});
        check("t1_no_reg_write", count_where(1), 0);

        // T3: lw with three MEMRD stall cycles
        hist.delete();
        run_instr(OP_LW, 0, 3, 0);
        settle();
        check("t3_len", hist.size(), 8);
        check("t3_memrd_cycles", count_where(5), 4);
        check("t3_memrd_iord", count_where(0), 4);
        check("t3_one_mdr_write", {count_where(1), count_where(2)}, {32'd1, 32'd1});

        // lw without stalls, 5 cycles
        hist.delete();
        run_instr(OP_LW, 0, 0, 0);
        settle();
        check("lw_len", hist.size(), 5);

        // T4: beq taken, then not taken
        hist.delete();
        run_instr(OP_BEQ, 0, 0, 1);
        settle();
        check("t4_len", hist.size(), 3);
        check("t4_taken", {hst(2).pc_en, hst(2).pc_src, hst(2).alu_op}, 6'b1_01_110);
        hist.delete();
        run_instr(OP_BEQ, 0, 0, 0);
        settle();
        check("t4_not_taken", {hst(2).pc_en, hst(2).pc_src, hst(2).alu_op}, 6'b0_01_110);

        // T5: unknown opcode in DECODE
        hist.delete();
        run_instr(OP_BAD, 0, 0, 0);
        settle();
        check("t5_len", hist.size(), 2);
        check("t5_illegal_pulse", {hst(0).illegal, hst(1).illegal}, 2'b01);
        check("t5_no_writes", count_where(4), 0);

        // T6: sw then j back to back
        hist.delete();
        run_instr(OP_SW, 0, 0, 0);
        run_instr(OP_J, 0, 0, 0);
        settle();
        check("t6_len", hist.size(), 7);
        check("t6_single_mem_write", count_where(3), 1);
        check("t6_jump", {hst(6).state, hst(6).pc_en, hst(6).pc_src}, {4'd11, 1'b1, 2'b10});

        // addi with two FETCH stall cycles, then sw with two MEMWR stall cycles
        hist.delete();
        run_instr(OP_ADDI, 2, 0, 0);
        settle();
        check("addi_stalled_len", hist.size(), 6);
        check("addi_wb", {hst(5).state, hst(5).reg_write, hst(5).reg_dst, hst(5).mem_to_reg},
              {4'd10, 3'b100});
        hist.delete();
        run_instr(OP_SW, 0, 2, 0);
        settle();
        check("sw_stalled_mem_write", count_where(3), 3);

        // The instruction that follows shows that the DUT is back in FETCH
        run_instr(OP_R, 1, 0, 0);
        settle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
